// File: rtl/dda_out_stream_sender.sv
// Transmit end of the DDA-out stream. One column result from the DDA core is
// accepted per handshake. Its line height is clamped and the beat is packed and
// queued in a small FIFO with its end-of-frame flag. The FIFO head drives an
// AXI-stream style tvalid/tdata/tlast interface under tready backpressure.
// Each frame carries exactly SCREEN_WIDTH columns and is opened by new_frame_in.
module dda_out_stream_sender #(
  parameter int SCREEN_WIDTH  = 320,
  parameter int SCREEN_HEIGHT = 240,
  parameter int DEPTH         = 4
) (
  input  logic        pixel_clk_in,
  input  logic        rst_in,
  input  logic        new_frame_in,
  input  logic        col_valid_in,
  output logic        col_ready_out,
  input  logic [8:0]  col_hcount_in,
  input  logic [15:0] col_line_height_in,
  input  logic        col_wall_type_in,
  input  logic [3:0]  col_map_data_in,
  input  logic [15:0] col_wallx_in,
  output logic        dda_fsm_out_tvalid,
  input  logic        dda_fsm_out_tready,
  output logic [37:0] dda_fsm_out_tdata,
  output logic        dda_fsm_out_tlast,
  output logic        frame_done_out,
  output logic        seq_error_out
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int BEAT_W = 38;

  localparam logic [15:0]      LH_MAX16 = 16'(SCREEN_HEIGHT);
  localparam logic [7:0]       LH_MAX8  = 8'(SCREEN_HEIGHT);
  localparam logic [8:0]       LAST_COL = 9'(SCREEN_WIDTH - 1);
  localparam logic [8:0]       COL_ONE  = 9'd1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  typedef enum logic {WAIT_FRAME, STREAM} state_t;

  state_t state_q, state_d;

  logic [8:0]        col_cnt_q;
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  fifo_cnt_q;
  logic [BEAT_W:0]   fifo_mem [DEPTH];
  logic [BEAT_W:0]   fifo_head;
  logic              fifo_full, fifo_empty;
  logic              col_accept, col_last, beat_pop;

  // Saturate the wall height to the screen height; the result always fits 8 bits.
  function automatic logic [7:0] clamp_height(input logic [15:0] lh);
    if (lh > LH_MAX16) begin
      return LH_MAX8;
    end
    return lh[7:0];
  endfunction

  // Beat layout, MSB first: hcount, clamped height, side, map cell, wall fraction.
  function automatic logic [BEAT_W-1:0] pack_beat(
    input logic [8:0]  hcount,
    input logic [15:0] lh,
    input logic        wall_type,
    input logic [3:0]  map_data,
    input logic [15:0] wallx
  );
    return {hcount, clamp_height(lh), wall_type, map_data, wallx};
  endfunction

  assign fifo_full  = (fifo_cnt_q == CNT_FULL);
  assign fifo_empty = (fifo_cnt_q == '0);
  assign col_accept = col_valid_in & col_ready_out;
  assign col_last   = (col_cnt_q == LAST_COL);
  assign beat_pop   = dda_fsm_out_tvalid & dda_fsm_out_tready;

  // Frame state register.
  always_ff @(posedge pixel_clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= WAIT_FRAME;
    end else begin
      state_q <= state_d;
    end
  end

  // Open a frame on new_frame_in; close it once the last column is accepted.
  always_comb begin
    state_d = state_q;
    case (state_q)
      WAIT_FRAME: if (new_frame_in) state_d = STREAM;
      STREAM:     if (col_accept && col_last) state_d = WAIT_FRAME;
      default:    state_d = WAIT_FRAME;
    endcase
  end

  // Acceptance only inside a frame, and only when the FIFO has a free slot
  // before any same-cycle pop is taken into account.
  always_comb begin
    col_ready_out = 1'b0;
    if (state_q == STREAM) begin
      col_ready_out = !fifo_full;
    end
  end

  // Column position within the frame; restarts at zero when a frame opens.
  always_ff @(posedge pixel_clk_in or negedge rst_in) begin
    if (!rst_in) begin
      col_cnt_q <= '0;
    end else if (state_q == WAIT_FRAME && new_frame_in) begin
      col_cnt_q <= '0;
    end else if (col_accept) begin
      col_cnt_q <= col_last ? 9'd0 : col_cnt_q + COL_ONE;
    end
  end

  // Sticky flag for a column arriving out of order; the beat itself still goes out.
  always_ff @(posedge pixel_clk_in or negedge rst_in) begin
    if (!rst_in) begin
      seq_error_out <= 1'b0;
    end else if (col_accept && (col_hcount_in != col_cnt_q)) begin
      seq_error_out <= 1'b1;
    end
  end

  // FIFO storage: data only, the end-of-frame flag travels with each beat.
  always_ff @(posedge pixel_clk_in) begin
    if (col_accept) begin
      fifo_mem[wr_ptr_q] <= {col_last, pack_beat(col_hcount_in, col_line_height_in,
                                                 col_wall_type_in, col_map_data_in,
                                                 col_wallx_in)};
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally as DEPTH is a power of two.
  always_ff @(posedge pixel_clk_in or negedge rst_in) begin
    if (!rst_in) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      if (col_accept) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (beat_pop)   rd_ptr_q <= rd_ptr_q + PTR_ONE;
      case ({col_accept, beat_pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + CNT_ONE;
        2'b01:   fifo_cnt_q <= fifo_cnt_q - CNT_ONE;
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
    end
  end

  // Stream side reads the registered head; outputs are forced low while empty
  // so they read zero straight out of reset.
  assign fifo_head          = fifo_mem[rd_ptr_q];
  assign dda_fsm_out_tvalid = !fifo_empty;
  assign dda_fsm_out_tdata  = fifo_empty ? '0 : fifo_head[BEAT_W-1:0];
  assign dda_fsm_out_tlast  = !fifo_empty & fifo_head[BEAT_W];

  // One-cycle pulse after the end-of-frame beat leaves.
  always_ff @(posedge pixel_clk_in or negedge rst_in) begin
    if (!rst_in) begin
      frame_done_out <= 1'b0;
    end else begin
      frame_done_out <= beat_pop & dda_fsm_out_tlast;
    end
  end

endmodule

// File: doc/dda_out_stream_sender.md
Name: dda_out_stream_sender

Overview:
- Transmit end of the DDA-out stream, the interface the transformation (flattening) block consumes.
- Accepts one per-column result from the DDA core through a valid/ready handshake.
- Clamps the line height, packs the 38-bit beat, buffers it in a small FIFO, and drives AXI-stream tvalid/tdata/tlast under tready backpressure.
- Frames exactly SCREEN_WIDTH columns per video frame and starts each frame on new_frame_in.

Parameters:
- SCREEN_WIDTH, 320, columns per frame; the tlast beat is index SCREEN_WIDTH-1.
- SCREEN_HEIGHT, 240, clamp ceiling for line height; must be ≤255.
- DEPTH, 4, FIFO entries; power of 2, ≥2.

Ports:
- pixel_clk_in  in  1  pixel clock (only clock)
- rst_in  in  1  asynchronous, active-low reset
- new_frame_in  in  1  one-cycle new-frame pulse from video_sig_gen
- col_valid_in  in  1  DDA column result valid
- col_ready_out  out  1  sender can accept a column
- col_hcount_in  in  9  column index
- col_line_height_in  in  16  unclamped wall line height
- col_wall_type_in  in  1  side hit (0 = X, 1 = Y)
- col_map_data_in  in  4  map cell value
- col_wallx_in  in  16  wall-hit fraction
- dda_fsm_out_tvalid  out  1  stream beat valid
- dda_fsm_out_tready  in  1  receiver ready
- dda_fsm_out_tdata  out  38  packed beat
- dda_fsm_out_tlast  out  1  last column of frame
- frame_done_out  out  1  one-cycle pulse when the tlast beat handshakes
- seq_error_out  out  1  sticky column-order error

Behaviour:
- Reset (rst_in=0, asynchronous):
  - state=WAIT_FRAME, FIFO empty, column counter=0.
  - All outputs 0: col_ready_out, tvalid, tdata, tlast, frame_done_out, seq_error_out.
- Packing, MSB→LSB: tdata = {hcount[8:0], lh[7:0], wall_type, map_data[3:0], wallx[15:0]}.
  - lh = min(col_line_height_in, SCREEN_HEIGHT), truncated to 8 bits.
  - Example: 1000 → 240 (0xF0).
- Per-entry tlast is stored in the FIFO with the data.
- States:
  - WAIT_FRAME: col_ready_out=0. new_frame_in=1 → STREAM, counter=0.
  - STREAM: col_ready_out = !fifo_full. This ignores a same-cycle pop; the full FIFO does not accept even while tready drains.
    - Column accepted (col_valid_in & col_ready_out): push, counter+1.
    - The accepted beat with counter==SCREEN_WIDTH-1 gets tlast=1 → WAIT_FRAME.
  - new_frame_in during STREAM is ignored; no restart mid-frame.
- Sequence check:
  - If an accepted col_hcount_in ≠ counter, seq_error_out latches 1 until reset.
  - The beat is still forwarded unchanged, and tlast is still determined by counter, not hcount.
- Stream output:
  - FIFO head is registered. A column accepted at edge N gives tvalid=1 with that data from N+1 at the earliest.
  - tvalid = !fifo_empty.
  - tdata/tlast are held stable while tvalid & !tready.
  - Pop on tvalid & tready.
- Simultaneous push and pop (FIFO neither empty nor full): occupancy unchanged, order preserved.
- Drain across frames:
  - WAIT_FRAME→STREAM on new_frame_in happens even if the FIFO still holds the previous frame's tail.
  - The previous frame's tlast beat leaves before any new-frame beat.
- frame_done_out: 1 for exactly the cycle after the tlast beat handshakes.
- Reset mid-frame: FIFO contents discarded; tvalid drops asynchronously; next frame starts at column 0 after the next new_frame_in.
- Occupancy counter width: $clog2(DEPTH)+1. Pointers wrap modulo DEPTH.

Test Plan:
1. Reset then new_frame pulse; feed 320 columns, hcount 0..319, lh=100, tready=1 → 320 beats in order; tlast only on hcount 319. tdata for hcount 5, wall_type 1, map 3, wallx 0x1234 = {9'd5, 8'd100, 1, 4'd3, 16'h1234}. frame_done_out pulses once.
2. col_line_height_in = 0, 239, 240, 241, 0xFFFF → packed lh = 0, 239, 240, 240, 240.
3. Hold tready=0 with col_valid_in=1 → exactly 4 columns accepted, then col_ready_out=0; tdata/tvalid stable. Release tready → beats 0..3 exit one per cycle and acceptance resumes.
4. Random tready (50%) over 3 frames with new_frame pulses mid-drain → no loss or duplication; exactly 3 tlast beats; no column accepted in WAIT_FRAME.
5. Feed hcount sequence 0,1,3,… → seq_error_out=1 from the cycle after the bad beat until reset; beat count and tlast position unchanged.
6. Assert rst_in=0 with 3 beats buffered mid-frame → tvalid=0 immediately. After release and new_frame, the first beat carries hcount 0.
